// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: the fetch-queue entry, the canonical NOP and PC alignment.
package cpu_pkg;

   localparam int          CPU_XLEN  = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [CPU_XLEN-1:0] pc;
      logic [31:0]         instr;
      logic                filled;
   } fetch_entry_t;

   function automatic logic [CPU_XLEN-1:0] align_pc(input logic [CPU_XLEN-1:0] addr);
      return {addr[CPU_XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries are allocated with their PC when the request is accepted
// and filled later by responses, oldest unfilled first; the head pops once it holds an instruction.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                alloc,
   input  logic [CPU_XLEN-1:0] alloc_pc,
   input  logic                fill,
   input  logic [31:0]         fill_instr,
   input  logic                pop,
   output logic                head_valid,
   output logic                head_filled,
   output logic [CPU_XLEN-1:0] head_pc,
   output logic [31:0]         head_instr,
   output logic [CW-1:0]       occupancy,
   output logic [CW-1:0]       unfilled_count
);

   fetch_entry_t  entries_q [DEPTH];
   fetch_entry_t  entries_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] fill_ptr_q, fill_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] occ_q, occ_d;
   logic [CW-1:0] unf_q, unf_d;

   always_comb begin
      entries_d  = entries_q;
      wr_ptr_d   = wr_ptr_q;
      fill_ptr_d = fill_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      unf_d      = unf_q;
      if (clear) begin
         // Stale entry contents are left in place; the counters alone define what is live.
         wr_ptr_d   = '0;
         fill_ptr_d = '0;
         rd_ptr_d   = '0;
         occ_d      = '0;
         unf_d      = '0;
      end else begin
         if (alloc) begin
            entries_d[wr_ptr_q] = '{pc: alloc_pc, instr: NOP_INSTR, filled: 1'b0};
            wr_ptr_d            = wr_ptr_q + PW'(1);
         end
         if (fill) begin
            entries_d[fill_ptr_q].instr  = fill_instr;
            entries_d[fill_ptr_q].filled = 1'b1;
            fill_ptr_d                   = fill_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         occ_d = occ_q + CW'(alloc) - CW'(pop);
         unf_d = unf_q + CW'(alloc) - CW'(fill);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         fill_ptr_q <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         unf_q      <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         fill_ptr_q <= fill_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         unf_q      <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      entries_q <= entries_d;
   end

   assign head_valid     = (occ_q != '0);
   assign head_filled    = entries_q[rd_ptr_q].filled;
   assign head_pc        = entries_q[rd_ptr_q].pc;
   assign head_instr     = entries_q[rd_ptr_q].instr;
   assign occupancy      = occ_q;
   assign unfilled_count = unf_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order requests to a variable-latency memory,
// buffers responses in fetch_queue and drives the IF/ID register under stall and redirect control.
module if_stage
   import cpu_pkg::*;
#(
   parameter int              XLEN     = CPU_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              QDEPTH   = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            pc_write,
   input  logic            if_id_write,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_instr
);

   localparam int CW = $clog2(QDEPTH + 1);
   // Headroom for responses still owed by requests issued before back-to-back redirects.
   localparam int DW = CW + 3;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [DW-1:0]   discard_q, discard_d;
   logic            if_id_valid_q, if_id_valid_d;
   logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
   logic [31:0]     if_id_instr_q, if_id_instr_d;

   logic            head_valid, head_filled;
   logic [XLEN-1:0] head_pc;
   logic [31:0]     head_instr;
   logic [CW-1:0]   occupancy, unfilled_count;

   logic req_valid, accept, disc_active, rsp_drop, rsp_fill, pop;

   assign req_valid   = rst_n & pc_write & ~redirect_valid & (occupancy < CW'(QDEPTH));
   assign accept      = req_valid & imem_req_ready;
   assign disc_active = (discard_q != '0);
   assign rsp_drop    = imem_rsp_valid & disc_active;
   assign rsp_fill    = imem_rsp_valid & ~disc_active & ~redirect_valid;
   // The head must already be filled at the start of the cycle; a same-cycle fill cannot pop.
   assign pop         = ~redirect_valid & if_id_write & head_valid & head_filled;

   fetch_queue #(.DEPTH(QDEPTH)) u_queue (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear          (redirect_valid),
      .alloc          (accept),
      .alloc_pc       (pc_q),
      .fill           (rsp_fill),
      .fill_instr     (imem_rsp_data),
      .pop            (pop),
      .head_valid     (head_valid),
      .head_filled    (head_filled),
      .head_pc        (head_pc),
      .head_instr     (head_instr),
      .occupancy      (occupancy),
      .unfilled_count (unfilled_count)
   );

   always_comb begin
      pc_d          = pc_q;
      discard_d     = discard_q;
      if_id_valid_d = if_id_valid_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      if (redirect_valid) begin
         pc_d          = align_pc(redirect_pc);
         // Every response still owed to a pre-redirect request must be dropped.
         discard_d     = DW'(unfilled_count) - DW'(imem_rsp_valid & ~disc_active)
                         + (disc_active ? (discard_q - DW'(imem_rsp_valid)) : '0);
         if_id_valid_d = 1'b0;
         if_id_pc_d    = '0;
         if_id_instr_d = NOP_INSTR;
      end else begin
         if (accept) begin
            pc_d = pc_q + XLEN'(4);
         end
         if (rsp_drop) begin
            discard_d = discard_q - DW'(1);
         end
         if (if_id_write) begin
            if (pop) begin
               if_id_valid_d = 1'b1;
               if_id_pc_d    = head_pc;
               if_id_instr_d = head_instr;
            end else begin
               if_id_valid_d = 1'b0;
               if_id_pc_d    = '0;
               if_id_instr_d = NOP_INSTR;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         discard_q     <= '0;
         if_id_valid_q <= 1'b0;
         if_id_pc_q    <= '0;
         if_id_instr_q <= NOP_INSTR;
      end else begin
         pc_q          <= pc_d;
         discard_q     <= discard_d;
         if_id_valid_q <= if_id_valid_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
      end
   end

   assign imem_req_valid = req_valid;
   assign imem_req_addr  = pc_q;
   assign if_id_valid    = if_id_valid_q;
   assign if_id_pc       = if_id_pc_q;
   assign if_id_instr    = if_id_instr_q;

   a_rsp_legal: assert property (@(posedge clk) disable iff (!rst_n)
      (imem_rsp_valid && !disc_active) |-> (unfilled_count != '0));

   a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
      occupancy <= CW'(QDEPTH));

   a_redirect_no_req: assert property (@(posedge clk) disable iff (!rst_n)
      redirect_valid |-> !imem_req_valid);

endmodule
